// File: rtl/vm_pkg.sv
// Shared vending-machine types and constants.
// Holds the change engine state enum, the default denomination values
// and the hopper index constants used to address coin_sel / hopper_empty.
package vm_pkg;

  // Default amount width and denomination values (credit units)
  localparam int unsigned AMT_W_DEF     = 5;
  localparam int unsigned DENOM_HI_DEF  = 10;
  localparam int unsigned DENOM_MID_DEF = 5;
  localparam int unsigned DENOM_LO_DEF  = 1;

  // Number of hoppers and width of a hopper index
  localparam int unsigned N_DENOM = 3;
  localparam int unsigned SEL_W   = 2;

  // Hopper index constants: bit i of hopper_empty / value of coin_sel
  localparam logic [SEL_W-1:0] DEN_LO  = 2'd0;
  localparam logic [SEL_W-1:0] DEN_MID = 2'd1;
  localparam logic [SEL_W-1:0] DEN_HI  = 2'd2;

  // Change engine FSM states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CALC     = 3'd1,
    ST_SELECT   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_FINISH   = 3'd4
  } state_t;

endpackage

// File: rtl/denom_select.sv
// Greedy coin picker (combinational).
// Returns the largest denomination that fits in 'remaining' and whose
// hopper is not empty.
//   remaining    in  AMT_W    amount still owed
//   hopper_empty in  N_DENOM  bit i = hopper i is empty
//   sel          out SEL_W    chosen hopper index (DEN_LO when none found)
//   found        out 1        a denomination qualified
module denom_select
  import vm_pkg::*;
#(
  parameter int unsigned AMT_W     = AMT_W_DEF,
  parameter int unsigned DENOM_HI  = DENOM_HI_DEF,
  parameter int unsigned DENOM_MID = DENOM_MID_DEF,
  parameter int unsigned DENOM_LO  = DENOM_LO_DEF
) (
  input  logic [AMT_W-1:0]   remaining,
  input  logic [N_DENOM-1:0] hopper_empty,
  output logic [SEL_W-1:0]   sel,
  output logic               found
);

  // Priority from largest to smallest denomination
  always_comb begin
    sel   = DEN_LO;
    found = 1'b0;
    if (!hopper_empty[DEN_HI] && (remaining >= AMT_W'(DENOM_HI))) begin
      sel   = DEN_HI;
      found = 1'b1;
    end else if (!hopper_empty[DEN_MID] && (remaining >= AMT_W'(DENOM_MID))) begin
      sel   = DEN_MID;
      found = 1'b1;
    end else if (!hopper_empty[DEN_LO] && (remaining >= AMT_W'(DENOM_LO))) begin
      sel   = DEN_LO;
      found = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change engine for the vending machine.
// On start it computes the change owed (or a full refund) and pays it out
// one coin at a time over a valid/ack handshake, largest coin first,
// skipping empty hoppers. Reports done, dispensed total and shortfall.
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, accepted only when idle
//   refund              with start: return the full paid amount
//   paid_amount         with start: credit inserted
//   product_price       with start: selected price
//   hopper_empty        per-denomination empty flags
//   coin_ack            hopper driver accepted the pending coin
//   coin_valid/coin_sel pending coin request and its hopper index
//   busy                high whenever not idle
//   done                one-cycle completion pulse
//   insufficient        paid < price on the last request
//   short_change        change could not be fully paid
//   change_total        amount actually dispensed
//   shortfall           undispensed remainder
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned AMT_W     = AMT_W_DEF,
  parameter int unsigned DENOM_HI  = DENOM_HI_DEF,
  parameter int unsigned DENOM_MID = DENOM_MID_DEF,
  parameter int unsigned DENOM_LO  = DENOM_LO_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               refund,
  input  logic [AMT_W-1:0]   paid_amount,
  input  logic [AMT_W-1:0]   product_price,
  input  logic [N_DENOM-1:0] hopper_empty,
  input  logic               coin_ack,
  output logic               coin_valid,
  output logic [SEL_W-1:0]   coin_sel,
  output logic               busy,
  output logic               done,
  output logic               insufficient,
  output logic               short_change,
  output logic [AMT_W-1:0]   change_total,
  output logic [AMT_W-1:0]   shortfall
);

  // Value of a denomination given its hopper index
  function automatic logic [AMT_W-1:0] denom_val(input logic [SEL_W-1:0] s);
    logic [AMT_W-1:0] v;
    case (s)
      DEN_HI:  v = AMT_W'(DENOM_HI);
      DEN_MID: v = AMT_W'(DENOM_MID);
      default: v = AMT_W'(DENOM_LO);
    endcase
    return v;
  endfunction

  state_t           r_state, w_state_nxt;
  logic             r_refund, w_refund_nxt;
  logic [AMT_W-1:0] r_paid, w_paid_nxt;
  logic [AMT_W-1:0] r_price, w_price_nxt;
  logic [AMT_W-1:0] r_remaining, w_remaining_nxt;
  logic [AMT_W-1:0] r_total, w_total_nxt;
  logic [AMT_W-1:0] r_shortfall, w_shortfall_nxt;
  logic             r_insuf, w_insuf_nxt;
  logic             r_short, w_short_nxt;
  logic             r_coin_valid, w_coin_valid_nxt;
  logic [SEL_W-1:0] r_coin_sel, w_coin_sel_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic [SEL_W-1:0] w_sel;
  logic             w_found;

  denom_select #(
    .AMT_W     (AMT_W),
    .DENOM_HI  (DENOM_HI),
    .DENOM_MID (DENOM_MID),
    .DENOM_LO  (DENOM_LO)
  ) u_denom_select (
    .remaining    (r_remaining),
    .hopper_empty (hopper_empty),
    .sel          (w_sel),
    .found        (w_found)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_refund     <= 1'b0;
      r_paid       <= '0;
      r_price      <= '0;
      r_remaining  <= '0;
      r_total      <= '0;
      r_shortfall  <= '0;
      r_insuf      <= 1'b0;
      r_short      <= 1'b0;
      r_coin_valid <= 1'b0;
      r_coin_sel   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_refund     <= w_refund_nxt;
      r_paid       <= w_paid_nxt;
      r_price      <= w_price_nxt;
      r_remaining  <= w_remaining_nxt;
      r_total      <= w_total_nxt;
      r_shortfall  <= w_shortfall_nxt;
      r_insuf      <= w_insuf_nxt;
      r_short      <= w_short_nxt;
      r_coin_valid <= w_coin_valid_nxt;
      r_coin_sel   <= w_coin_sel_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_refund_nxt     = r_refund;
    w_paid_nxt       = r_paid;
    w_price_nxt      = r_price;
    w_remaining_nxt  = r_remaining;
    w_total_nxt      = r_total;
    w_shortfall_nxt  = r_shortfall;
    w_insuf_nxt      = r_insuf;
    w_short_nxt      = r_short;
    w_coin_valid_nxt = r_coin_valid;
    w_coin_sel_nxt   = r_coin_sel;
    w_done_nxt       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_refund_nxt    = refund;
          w_paid_nxt      = paid_amount;
          w_price_nxt     = product_price;
          w_total_nxt     = '0;
          w_shortfall_nxt = '0;
          w_insuf_nxt     = 1'b0;
          w_short_nxt     = 1'b0;
          w_state_nxt     = ST_CALC;
        end
      end

      // Insufficient payment also passes through SELECT with nothing owed,
      // so every no-coin completion reports done at the same latency.
      ST_CALC: begin
        if (r_refund) begin
          w_remaining_nxt = r_paid;
        end else if (r_paid >= r_price) begin
          w_remaining_nxt = r_paid - r_price;
        end else begin
          w_insuf_nxt     = 1'b1;
          w_remaining_nxt = '0;
        end
        w_state_nxt = ST_SELECT;
      end

      ST_SELECT: begin
        if (r_remaining == '0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_FINISH;
        end else if (w_found) begin
          w_coin_sel_nxt   = w_sel;
          w_coin_valid_nxt = 1'b1;
          w_state_nxt      = ST_WAIT_ACK;
        end else begin
          w_short_nxt     = 1'b1;
          w_shortfall_nxt = r_remaining;
          w_done_nxt      = 1'b1;
          w_state_nxt     = ST_FINISH;
        end
      end

      // Coin selection is frozen here; hopper_empty is not re-evaluated.
      ST_WAIT_ACK: begin
        if (coin_ack) begin
          w_remaining_nxt  = r_remaining - denom_val(r_coin_sel);
          w_total_nxt      = r_total + denom_val(r_coin_sel);
          w_coin_valid_nxt = 1'b0;
          w_coin_sel_nxt   = '0;
          w_state_nxt      = ST_SELECT;
        end
      end

      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign coin_valid   = r_coin_valid;
  assign coin_sel     = r_coin_sel;
  assign busy         = r_busy;
  assign done         = r_done;
  assign insufficient = r_insuf;
  assign short_change = r_short;
  assign change_total = r_total;
  assign shortfall    = r_shortfall;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus
// randomized transactions compared against a greedy-change reference model.
module tb_change_dispenser;

  localparam int unsigned AMT_W = 5;
  localparam int unsigned D_HI  = 10;
  localparam int unsigned D_MID = 5;
  localparam int unsigned D_LO  = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             refund;
  logic [AMT_W-1:0] paid_amount;
  logic [AMT_W-1:0] product_price;
  logic [2:0]       hopper_empty;
  logic             coin_ack;
  logic             coin_valid;
  logic [1:0]       coin_sel;
  logic             busy;
  logic             done;
  logic             insufficient;
  logic             short_change;
  logic [AMT_W-1:0] change_total;
  logic [AMT_W-1:0] shortfall;

  int checks   = 0;
  int failures = 0;

  change_dispenser #(
    .AMT_W     (AMT_W),
    .DENOM_HI  (D_HI),
    .DENOM_MID (D_MID),
    .DENOM_LO  (D_LO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .refund        (refund),
    .paid_amount   (paid_amount),
    .product_price (product_price),
    .hopper_empty  (hopper_empty),
    .coin_ack      (coin_ack),
    .coin_valid    (coin_valid),
    .coin_sel      (coin_sel),
    .busy          (busy),
    .done          (done),
    .insufficient  (insufficient),
    .short_change  (short_change),
    .change_total  (change_total),
    .shortfall     (shortfall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction: start, then follow every cycle against the model.
  task automatic run_txn(input string name, input int paid, input int price,
                         input bit rf, input logic [2:0] he,
                         input int dly_min, input int dly_max, input bit poke);
    int  q[$];
    int  dv[3];
    int  rem, tot, d;
    bit  exp_insuf, exp_short, fnd;
    dv[0] = D_LO; dv[1] = D_MID; dv[2] = D_HI;

    // Reference: greedy largest-first over non-empty hoppers
    exp_insuf = !rf && (paid < price);
    rem = rf ? paid : ((paid >= price) ? paid - price : 0);
    tot = 0;
    while (rem > 0) begin
      fnd = 1'b0;
      for (int i = 2; i >= 0; i--) begin
        if (!fnd && !he[i] && dv[i] <= rem) begin
          q.push_back(i);
          rem -= dv[i];
          tot += dv[i];
          fnd = 1'b1;
        end
      end
      if (!fnd) break;
    end
    exp_short = (rem > 0);

    hopper_empty  = he;
    paid_amount   = AMT_W'(paid);
    product_price = AMT_W'(price);
    refund        = rf;
    start         = 1'b1;
    step();
    // cycle 1: inputs already latched, scramble them
    start         = 1'b0;
    paid_amount   = AMT_W'($urandom);
    product_price = AMT_W'($urandom);
    refund        = 1'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || change_total !== '0 ||
        insufficient !== 1'b0 || short_change !== 1'b0 || shortfall !== '0) begin
      failures++;
      $display("FAIL %s cycle1: busy=%b done=%b total=%0d insuf=%b short=%b sf=%0d (want 1 0 0 0 0 0)",
               name, busy, done, change_total, insufficient, short_change, shortfall);
    end
    if (poke) begin
      start = 1'b1; paid_amount = 5'd31; product_price = 5'd0; refund = 1'b1;
    end
    step();
    // cycle 2
    start = 1'b0;
    checks++;
    if (coin_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s cycle2: coin_valid=%b done=%b (want 0 0)", name, coin_valid, done);
    end
    step();
    // cycle 3
    for (int j = 0; j < q.size(); j++) begin
      if (j > 0) begin
        step();
        coin_ack = 1'b0;
      end
      checks++;
      if (coin_valid !== 1'b1 || coin_sel !== 2'(q[j])) begin
        failures++;
        $display("FAIL %s coin%0d: valid=%b sel=%0d (want 1 %0d)", name, j, coin_valid, coin_sel, q[j]);
      end
      d = $urandom_range(dly_max, dly_min);
      for (int c = 0; c < d; c++) begin
        if (poke && j == 0 && c == 0) begin
          start = 1'b1; paid_amount = 5'd31; product_price = 5'd0; refund = 1'b1;
        end
        step();
        start = 1'b0;
        checks++;
        if (coin_valid !== 1'b1 || coin_sel !== 2'(q[j])) begin
          failures++;
          $display("FAIL %s hold%0d.%0d: valid=%b sel=%0d (want 1 %0d)", name, j, c, coin_valid, coin_sel, q[j]);
        end
      end
      coin_ack = 1'b1;
      step();
      // ack taken; a stray ack while coin_valid is low must be ignored
      coin_ack = 1'($urandom);
      checks++;
      if (coin_valid !== 1'b0 || coin_sel !== 2'd0 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s gap%0d: valid=%b sel=%0d done=%b (want 0 0 0)", name, j, coin_valid, coin_sel, done);
      end
    end
    if (q.size() > 0) begin
      step();
      coin_ack = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || coin_valid !== 1'b0 ||
        change_total !== AMT_W'(tot) || shortfall !== AMT_W'(rem) ||
        short_change !== exp_short || insufficient !== exp_insuf) begin
      failures++;
      $display("FAIL %s done: done=%b busy=%b valid=%b total=%0d sf=%0d short=%b insuf=%b (want 1 1 0 %0d %0d %b %b)",
               name, done, busy, coin_valid, change_total, shortfall, short_change, insufficient,
               tot, rem, exp_short, exp_insuf);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || change_total !== AMT_W'(tot) ||
        shortfall !== AMT_W'(rem) || short_change !== exp_short || insufficient !== exp_insuf) begin
      failures++;
      $display("FAIL %s after: done=%b busy=%b total=%0d sf=%0d short=%b insuf=%b (want 0 0 %0d %0d %b %b)",
               name, done, busy, change_total, shortfall, short_change, insufficient,
               tot, rem, exp_short, exp_insuf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; refund = 1'b0; paid_amount = '0;
    product_price = '0; hopper_empty = 3'b000; coin_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({coin_valid, coin_sel, busy, done, insufficient, short_change} !== 7'd0 ||
        change_total !== '0 || shortfall !== '0) begin
      failures++;
      $display("FAIL reset: valid=%b sel=%0d busy=%b done=%b insuf=%b short=%b total=%0d sf=%0d (want all 0)",
               coin_valid, coin_sel, busy, done, insufficient, short_change, change_total, shortfall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    run_txn("normal",     17, 5,  1'b0, 3'b000, 0, 0, 1'b0);
    run_txn("exact",      8,  8,  1'b0, 3'b000, 0, 0, 1'b0);
    run_txn("insuff",     3,  9,  1'b0, 3'b000, 0, 0, 1'b0);
    run_txn("skip_hi",    20, 5,  1'b0, 3'b100, 0, 1, 1'b0);
    run_txn("shortfall",  18, 10, 1'b0, 3'b001, 0, 0, 1'b0);
    run_txn("all_empty",  9,  2,  1'b0, 3'b111, 0, 0, 1'b0);
    run_txn("max_refund", 31, 31, 1'b1, 3'b000, 0, 2, 1'b0);
  endtask

  task automatic test_refund_protocol();
    run_txn("refund13",    13, 20, 1'b1, 3'b000, 4, 4, 1'b0);
    run_txn("start_busy",  16, 0,  1'b0, 3'b000, 2, 3, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      run_txn("rand", int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
              ($urandom_range(3, 0) == 0), 3'($urandom), 0, 3, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    hopper_empty = 3'b000; paid_amount = 5'd20; product_price = 5'd0;
    refund = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (coin_valid !== 1'b1 || coin_sel !== 2'd2) begin
      failures++;
      $display("FAIL rst_mid pre: valid=%b sel=%0d (want 1 2)", coin_valid, coin_sel);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({coin_valid, coin_sel, busy, done, insufficient, short_change} !== 7'd0 ||
        change_total !== '0 || shortfall !== '0) begin
      failures++;
      $display("FAIL rst_mid: valid=%b sel=%0d busy=%b done=%b total=%0d (want all 0)",
               coin_valid, coin_sel, busy, done, change_total);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_txn("post_rst", 12, 1, 1'b0, 3'b000, 0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_refund_protocol();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
